spi_read_ctrl: RTL and testbench

Control stage of the SPI read path, sitting directly upstream of the dclk pulse counter: it drives the counter's 2-bit opcode, reads the count back, and uses it to decide when a read ends. Per transaction it drives chip-select, generates dclk from the system clock, shifts in MISO MSB-first, and presents the received word with a one-cycle done strobe. SPI mode 0: dclk idles low, sampling on the dclk rising edge.

---
 rtl/spi_read_ctrl_pkg.sv | 17 +
 rtl/spi_read_ctrl_timer.sv | 26 ++
 rtl/spi_read_ctrl.sv | 92 +++++++++
 tb/tb_spi_read_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_read_ctrl_pkg.sv
// Shared SPI read-path definitions: pulse-counter opcodes and controller state encoding.
package spi_read_ctrl_pkg;

   localparam logic [1:0] OPC_CLR  = 2'b00;
   localparam logic [1:0] OPC_HOLD = 2'b01;
   localparam logic [1:0] OPC_INC  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_HOLD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/spi_read_ctrl_timer.sv
// Half-period timer: counts 0..HalfPeriod-1, flags the last cycle of a phase, clears on request.
module half_period_timer #(
   parameter int HalfPeriod = 4,
   parameter int DivW       = $clog2(HalfPeriod)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic end_o
);

   logic [DivW-1:0] div_q, div_d;

   assign end_o = (div_q == DivW'(HalfPeriod - 1));

   always_comb begin
      div_d = div_q + 1'b1;
      if (clr_i || end_o) div_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) div_q <= '0;
      else       div_q <= div_d;
   end

endmodule

// File: rtl/spi_read_ctrl.sv
// SPI mode-0 read controller: drives cs/dclk, shifts MISO MSB-first, and ends the
// read when the external dclk pulse counter reports Width (or more) increments.
module spi_read_ctrl
   import spi_read_ctrl_pkg::*;
#(
   parameter int Width      = 16,
   parameter int CntWidth   = 6,
   parameter int HalfPeriod = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                miso_i,
   input  logic [CntWidth-1:0] cnt_i,
   output logic [1:0]          opc_o,
   output logic                cs_o,
   output logic                dclk_o,
   output logic [Width-1:0]    data_o,
   output logic                done_o,
   output logic                busy_o
);

   state_e           state_q, state_d;
   logic [Width-1:0] sr_q, data_q;
   logic             cs_q, dclk_q, done_q, busy_q;
   logic             ph_end;

   half_period_timer #(.HalfPeriod(HalfPeriod)) u_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_d != state_q),
      .end_o (ph_end)
   );

   // opc_o is a pure decode of state and timer so the counter sees one INC per HIGH phase
   always_comb begin
      state_d = state_q;
      opc_o   = OPC_HOLD;
      unique case (state_q)
         ST_IDLE: begin
            opc_o = OPC_CLR;
            if (start_i) state_d = ST_SETUP;
         end
         ST_SETUP: if (ph_end) state_d = ST_HIGH;
         ST_HIGH: if (ph_end) begin
            opc_o   = OPC_INC;
            state_d = ST_LOW;
         end
         // a count beyond Width is a counter fault; finish the read rather than hang
         ST_LOW: if (ph_end) state_d = (cnt_i >= CntWidth'(Width)) ? ST_HOLD : ST_HIGH;
         ST_HOLD: if (ph_end) state_d = ST_DONE;
         ST_DONE: begin
            opc_o   = OPC_CLR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cs_q    <= 1'b1;
         dclk_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_q    <= (state_d == ST_IDLE) || (state_d == ST_DONE);
         dclk_q  <= (state_d == ST_HIGH);
         done_q  <= (state_d == ST_DONE);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q   <= '0;
         data_q <= '0;
      end else begin
         if (state_d == ST_HIGH && state_q != ST_HIGH) sr_q <= {sr_q[Width-2:0], miso_i};
         if (state_d == ST_DONE) data_q <= sr_q;
      end
   end

   assign cs_o   = cs_q;
   assign dclk_o = dclk_q;
   assign done_o = done_q;
   assign busy_o = busy_q;
   assign data_o = data_q;

endmodule

// File: tb/tb_spi_read_ctrl.sv
// Scoreboard bench for spi_read_ctrl with a slave model, a pulse-counter model and a queue of expected reads.
module tb_spi_read_ctrl;

   localparam int W  = 16;
   localparam int CW = 6;
   localparam int H  = 4;
   localparam int P  = 2 * H * (W + 1) + 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          miso_i;
   logic [CW-1:0] cnt_i;
   logic [1:0]    opc_o;
   logic          cs_o, dclk_o, done_o, busy_o;
   logic [W-1:0]  data_o;

   spi_read_ctrl #(.Width(W), .CntWidth(CW), .HalfPeriod(H)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .miso_i  (miso_i),
      .cnt_i   (cnt_i),
      .opc_o   (opc_o),
      .cs_o    (cs_o),
      .dclk_o  (dclk_o),
      .data_o  (data_o),
      .done_o  (done_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] data;
      int           cyc;
      int           nb;
   } exp_t;

   exp_t         sb[$];
   int           n_chk = 0, n_fail = 0;
   int           cyc = 0;
   int           rises = 0, tx_rises = 0;
   logic         dclk_prev = 1'b0;
   logic [W-1:0] cur_word = '0;
   logic [W-1:0] model_sr = '0;
   logic [W-1:0] shown_data = '0;
   logic         fault_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // pulse-counter model; with fault_en set it jumps past Width on the 6th increment
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_i <= '0;
      else case (opc_o)
         2'b00:   cnt_i <= '0;
         2'b10:   cnt_i <= (fault_en && cnt_i == CW'(5)) ? CW'(W + 1) : cnt_i + CW'(1);
         default: cnt_i <= cnt_i;
      endcase
   end

   // slave: presents cur_word MSB-first, advancing after each dclk rise
   initial begin
      miso_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         if (cs_o) begin
            if (rises != 0) tx_rises = rises;
            rises = 0;
         end else if (dclk_o && !dclk_prev) rises++;
         dclk_prev = dclk_o;
         miso_i = (rises < W) ? cur_word[W-1-rises] : 1'b0;
      end
   end

   // monitor
   initial forever begin
      @(negedge clk_i);
      if (!rst_i) begin
         chk("opc_legal", (opc_o != 2'b11), 1);
         if (done_o) begin
            if (sb.size() == 0) chk("unexpected_done", done_o, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_data", data_o, e.data);
               chk("done_cycle", cyc, e.cyc);
               chk("dclk_rises", tx_rises, e.nb);
               chk("done_cs", cs_o, 1);
               chk("done_busy", busy_o, 1);
               chk("done_opc", opc_o, 2'b00);
               shown_data = e.data;
            end
         end else begin
            chk("data_stable", data_o, shown_data);
            if (busy_o) chk("cs_active", cs_o, 0);
            else begin
               chk("idle_cs", cs_o, 1);
               chk("idle_dclk", dclk_o, 0);
               chk("idle_opc", opc_o, 2'b00);
            end
         end
      end
   end

   task automatic wait_empty(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      chk("done_timeout", sb.size(), 0);
      sb.delete();
      @(negedge clk_i);
   endtask

   task automatic run_txn(input logic [W-1:0] w, input int nb, input bit pulse);
      int e0, d;
      logic [W-1:0] ex;
      @(negedge clk_i);
      cur_word = w;
      start_i  = 1'b1;
      e0 = cyc + 1;
      d  = e0 + 2 * H * (nb + 1);
      ex = (nb == W) ? w : ((model_sr << nb) | (w >> (W - nb)));
      model_sr = ex;
      sb.push_back('{ex, d, nb});
      @(negedge clk_i);
      start_i = 1'b0;
      if (pulse) repeat (4) begin
         repeat ($urandom_range(5, 30)) @(negedge clk_i);
         if (cyc + 1 <= d - 2) begin
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
         end
      end
      wait_empty(2 * H * (W + 2) + 20);
   endtask

   initial begin
      int e0, k;
      rst_i   = 1'b1;
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_cs", cs_o, 1);
      chk("rst_dclk", dclk_o, 0);
      chk("rst_opc", opc_o, 2'b00);
      chk("rst_done", done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_data", data_o, 0);
      rst_i = 1'b0;
      repeat (50) @(negedge clk_i);

      run_txn(16'hA5C3, W, 1'b0);

      // start_i held high: three back-to-back reads at minimum spacing
      @(negedge clk_i);
      cur_word = 16'hA5C3;
      start_i  = 1'b1;
      e0 = cyc + 1;
      for (int i = 0; i < 3; i++) sb.push_back('{16'hA5C3, e0 + i * P + 2 * H * (W + 1), W});
      model_sr = 16'hA5C3;
      repeat (2 * P + 1) @(negedge clk_i);
      start_i = 1'b0;
      wait_empty(P + 20);

      for (int i = 0; i < 3; i++) run_txn(W'($urandom), W, 1'b1);

      // reset after the 5th dclk rise
      @(negedge clk_i);
      cur_word = W'($urandom);
      start_i  = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      k = 0;
      while (rises < 5 && k < 500) begin
         @(negedge clk_i);
         k++;
      end
      chk("reach_rise5", rises, 5);
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrst_cs", cs_o, 1);
      chk("midrst_dclk", dclk_o, 0);
      chk("midrst_data", data_o, 0);
      chk("midrst_done", done_o, 0);
      model_sr   = '0;
      shown_data = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      run_txn(W'($urandom), W, 1'b0);

      // counter skips to Width+1 after six increments
      fault_en = 1'b1;
      run_txn(W'($urandom), 6, 1'b0);
      fault_en = 1'b0;
      run_txn(W'($urandom), W, 1'b0);

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk_i);
         run_txn(W'($urandom), W, 1'($urandom_range(0, 1)));
      end

      repeat (10) @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
